alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised successor to the 8-bit datapath ALU. Registered result bus with a valid pulse, and a start/busy handshake. Adds shifts, XOR/NOT and a multi-cycle shift-add multiplier. Carry, zero, negative and overflow flags live in internal flag registers, updated under write_cz. Sits between the A/B operand buses and the C bus of the CPU datapath; the controller sequences it via start/valid.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of 2)
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
clk_ALU  in  1  clock, rising edge
rst_ALU  in  1  reset, asynchronous, active-high
aBus  in  WIDTH  operand A
bBus  in  WIDTH  operand B
f  in  4  operation select
start  in  1  launch operation; sampled only when busy=0
write_cz  in  1  flag write enable; sampled with start
cBus  out  WIDTH  registered result
valid  out  1  one-cycle pulse: cBus and flags updated this cycle
busy  out  1  multi-cycle operation in progress
CF  out  1  carry/borrow flag
ZF  out  1  zero flag
NF  out  1  negative flag, cBus MSB
VF  out  1  signed overflow flag

Behaviour:
- Reset (async, rst_ALU=1): cBus=0, valid=0, busy=0, CF=ZF=NF=VF=0, FSM to IDLE, multiplier regs cleared. Reset mid-multiply aborts; no valid is produced.
- FSM states: IDLE, MUL, DONE.
- IDLE with start=1: aBus, bBus, f and write_cz are latched.
  - Single-cycle op: result registered at that edge; valid=1 next cycle. Latency 1; FSM stays IDLE.
  - f=1010/1011: go to MUL with busy=1.
- MUL: WIDTH cycles of shift-add on latched operands, 2*WIDTH-bit product, unsigned. Then DONE: cBus and flags written, valid=1, busy=0, return to IDLE. Start-to-valid = WIDTH+1 cycles.
- start while busy=1: ignored; latched operands are unaffected.
- Back-to-back single-cycle ops: start every cycle is legal; valid every cycle.
- Operations, result width WIDTH, carry from a WIDTH+1 internal sum:
  - 0000 A: C=0
  - 0001 B: C=0
  - 0010 A+1: C=carry out
  - 0011 B+1: C=carry out
  - 0100 A+B: C=carry out; V=signed overflow
  - 0101 A-B: C=borrow (A<B unsigned); V=signed overflow
  - 0110 A&B: C=0
  - 0111 A|B: C=0
  - 1000 A<<B[SHW-1:0]: C=last bit shifted out, 0 if amount 0
  - 1001 A>>B[SHW-1:0] logical: C=last bit shifted out, 0 if amount 0
  - 1010 MUL low half: C=1 if high half nonzero
  - 1011 MUL high half: C=0
  - 1100 A^B: C=0
  - 1101 ~A: C=0
  - 1110, 1111 reserved: cBus=0, valid pulses, flags unchanged regardless of write_cz
- V is 0 for all ops except ADD/SUB.
- Flags: Z = (cBus==0), N = cBus[WIDTH-1]. All four flags are written only when the valid cycle's latched write_cz=1; otherwise they hold.
- cBus holds its last result between valid pulses.
- Wrap-around: INC of all-ones gives 0 with C=1, Z=1. SUB wraps modulo 2^WIDTH.

Optional Feature:
ALU_OVERFLOW_FLAG_EN
- Defined: VF computed as above (ADD: A,B same sign and result sign differs; SUB: A,B signs differ and result sign differs from A).
- Undefined: VF tied to 0, overflow logic not synthesised; all other behaviour identical.

Test Plan:
- Reset: assert rst_ALU asynchronously mid-cycle -> all outputs 0 immediately; no valid after release.
- ADD, WIDTH=8, write_cz=1: A=0xFF, B=0x01 -> cBus=0x00, C=1, Z=1, N=0, V=0, valid 1 cycle after start.
- SUB, WIDTH=8, write_cz=1: A=0x80, B=0x01 -> cBus=0x7F, C=0, V=1 (macro defined) / V=0 (undefined). Then A=0x03, B=0x05 -> 0xFE, C=1, N=1.
- MUL, WIDTH=8: A=0x10, B=0x20, f=1010 -> busy 8 cycles, valid at cycle 9, cBus=0x00, C=1, Z=1; f=1011 same operands -> cBus=0x02. Extra start during busy (A=1, B=1) ignored.
- Shifts: A=0x81, B=0x01, f=1000 -> cBus=0x02, C=1; f=1001 -> cBus=0x40, C=1; B=0x00 -> cBus=0x81, C=0.
- Flag hold and reserved op: ADD with write_cz=0 after a Z=1 result -> flags unchanged, cBus updated; f=1110 with write_cz=1 -> cBus=0, flags unchanged; reset asserted during MUL -> busy=0, no valid.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result bus between the CPU datapath controller and alu_seq.
// master: controller side (drives operands and start); slave: the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] aBus;
  logic [WIDTH-1:0] bBus;
  logic [3:0]       f;
  logic             start;
  logic             write_cz;
  logic [WIDTH-1:0] cBus;
  logic             valid;
  logic             busy;
  logic             CF;
  logic             ZF;
  logic             NF;
  logic             VF;

  modport master (
    output aBus, bBus, f, start, write_cz,
    input  cBus, valid, busy, CF, ZF, NF, VF
  );

  modport slave (
    input  aBus, bBus, f, start, write_cz,
    output cBus, valid, busy, CF, ZF, NF, VF
  );
endinterface

// File: rtl/alu_seq.sv
// Sequenced datapath ALU: single-cycle arithmetic/logic/shift ops with a
// registered C bus and valid pulse, plus a WIDTH-cycle shift-add multiplier
// guarded by a start/busy handshake. Flags update only under write_cz.
// Optional feature macro: ALU_OVERFLOW_FLAG_EN (signed overflow flag VF;
// when undefined VF is tied low and no overflow logic exists).
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic     clk_ALU,
  input  logic     rst_ALU,
  alu_seq_if.slave alu
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  localparam logic [3:0] OP_A    = 4'b0000;
  localparam logic [3:0] OP_B    = 4'b0001;
  localparam logic [3:0] OP_INCA = 4'b0010;
  localparam logic [3:0] OP_INCB = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MULL = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_NOT  = 4'b1101;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cbus_q;
  logic             valid_q;
  logic             busy_q;
  logic             cf_q;
  logic             zf_q;
  logic             nf_q;
  logic [3:0]       f_q;
  logic             wcz_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    prod_q;
  logic [SHW-1:0]   cnt_q;

  // single-cycle datapath signals
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             flags_en_d;
  logic             is_mul_d;

  // multiplier signals
  logic [PW-1:0]    prod_d;
  logic [WIDTH-1:0] mul_res_d;
  logic             mul_carry_d;

`ifdef ALU_OVERFLOW_FLAG_EN
  logic             vf_q;
  logic             ovf_d;
`endif

  assign alu.cBus  = cbus_q;
  assign alu.valid = valid_q;
  assign alu.busy  = busy_q;
  assign alu.CF    = cf_q;
  assign alu.ZF    = zf_q;
  assign alu.NF    = nf_q;
`ifdef ALU_OVERFLOW_FLAG_EN
  assign alu.VF    = vf_q;
`else
  assign alu.VF    = 1'b0;
`endif

  // Single-cycle result and carry, computed from the live operand bus.
  always_comb begin
    ext_a      = {1'b0, alu.aBus};
    ext_b      = {1'b0, alu.bBus};
    sh         = alu.bBus[SHW-1:0];
    wide       = '0;
    res_d      = '0;
    carry_d    = 1'b0;
    flags_en_d = alu.write_cz;
    is_mul_d   = (alu.f == OP_MULL) || (alu.f == OP_MULH);
    case (alu.f)
      OP_A:    res_d = alu.aBus;
      OP_B:    res_d = alu.bBus;
      OP_INCA: begin
        wide    = ext_a + (WIDTH + 1)'(1);
        res_d   = wide[WIDTH-1:0];
        carry_d = wide[WIDTH];
      end
      OP_INCB: begin
        wide    = ext_b + (WIDTH + 1)'(1);
        res_d   = wide[WIDTH-1:0];
        carry_d = wide[WIDTH];
      end
      OP_ADD: begin
        wide    = ext_a + ext_b;
        res_d   = wide[WIDTH-1:0];
        carry_d = wide[WIDTH];
      end
      OP_SUB: begin
        // bit WIDTH of the extended difference is the unsigned borrow
        wide    = ext_a - ext_b;
        res_d   = wide[WIDTH-1:0];
        carry_d = wide[WIDTH];
      end
      OP_AND:  res_d = alu.aBus & alu.bBus;
      OP_OR:   res_d = alu.aBus | alu.bBus;
      OP_SHL: begin
        // the extra top bit catches the last bit shifted out (0 when sh==0)
        wide    = ext_a << sh;
        res_d   = wide[WIDTH-1:0];
        carry_d = wide[WIDTH];
      end
      OP_SHR: begin
        wide    = {alu.aBus, 1'b0} >> sh;
        res_d   = wide[WIDTH:1];
        carry_d = wide[0];
      end
      OP_MULL, OP_MULH: res_d = '0;
      OP_XOR:  res_d = alu.aBus ^ alu.bBus;
      OP_NOT:  res_d = ~alu.aBus;
      default: begin
        // reserved codes: zero result, flags never touched
        res_d      = '0;
        flags_en_d = 1'b0;
      end
    endcase
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  // Signed overflow for ADD/SUB only.
  always_comb begin
    ovf_d = 1'b0;
    if (alu.f == OP_ADD) begin
      ovf_d = (alu.aBus[WIDTH-1] == alu.bBus[WIDTH-1]) &&
              (res_d[WIDTH-1] != alu.aBus[WIDTH-1]);
    end else if (alu.f == OP_SUB) begin
      ovf_d = (alu.aBus[WIDTH-1] != alu.bBus[WIDTH-1]) &&
              (res_d[WIDTH-1] != alu.aBus[WIDTH-1]);
    end
  end
`endif

  // One shift-add step and the half selected for the final result.
  always_comb begin
    prod_d      = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    mul_res_d   = (f_q == OP_MULH) ? prod_d[PW-1:WIDTH] : prod_d[WIDTH-1:0];
    mul_carry_d = (f_q == OP_MULL) && (prod_d[PW-1:WIDTH] != '0);
  end

  // Control FSM, multiplier registers and registered outputs.
  always_ff @(posedge clk_ALU or posedge rst_ALU) begin
    if (rst_ALU) begin
      state_q  <= IDLE;
      cbus_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
      vf_q     <= 1'b0;
`endif
      f_q      <= '0;
      wcz_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          // last step: publish the product now so DONE is the valid cycle
          if (cnt_q == SHW'(WIDTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            cbus_q  <= mul_res_d;
            if (wcz_q) begin
              cf_q <= mul_carry_d;
              zf_q <= (mul_res_d == '0);
              nf_q <= mul_res_d[WIDTH-1];
`ifdef ALU_OVERFLOW_FLAG_EN
              vf_q <= 1'b0;
`endif
            end
          end
        end
        IDLE, DONE: begin
          // DONE has busy low, so it accepts a new start like IDLE
          state_q <= IDLE;
          if (alu.start) begin
            f_q   <= alu.f;
            wcz_q <= alu.write_cz;
            if (is_mul_d) begin
              state_q  <= MUL;
              busy_q   <= 1'b1;
              mcand_q  <= PW'(alu.aBus);
              mplier_q <= alu.bBus;
              prod_q   <= '0;
              cnt_q    <= '0;
            end else begin
              valid_q <= 1'b1;
              cbus_q  <= res_d;
              if (flags_en_d) begin
                cf_q <= carry_d;
                zf_q <= (res_d == '0);
                nf_q <= res_d[WIDTH-1];
`ifdef ALU_OVERFLOW_FLAG_EN
                vf_q <= ovf_d;
`endif
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
